// File: rtl/scale_param_sequencer_if.sv
// Downstream scale-record handshake (valid/accept) between the
// scale-parameter sequencer and the window scanner.
interface scale_param_sequencer_if #(
    parameter int FIXED_BITS = 32,
    parameter int WIN_BITS   = 16,
    parameter int ROW_BITS   = 10,
    parameter int COL_BITS   = 10
);
    logic                  scale_valid;
    logic                  scale_accept;
    logic [ROW_BITS-1:0]   scale_w;
    logic [COL_BITS-1:0]   scale_h;
    logic [FIXED_BITS-1:0] scale_sfx;
    logic [FIXED_BITS-1:0] scale_sfy;
    logic [WIN_BITS-1:0]   scale_true_win;
    logic [7:0]            scale_idx;

    modport master (
        output scale_valid,
        output scale_w,
        output scale_h,
        output scale_sfx,
        output scale_sfy,
        output scale_true_win,
        output scale_idx,
        input  scale_accept
    );

    modport slave (
        input  scale_valid,
        input  scale_w,
        input  scale_h,
        input  scale_sfx,
        input  scale_sfy,
        input  scale_true_win,
        input  scale_idx,
        output scale_accept
    );
endinterface

// File: rtl/scale_param_sequencer.sv
// Per-frame sequencer: clears and repeatedly starts the scale-parameter
// generator, filters scales against the window and presents them downstream.
module scale_param_sequencer #(
    parameter int FIXED_BITS = 32,
    parameter int WIN_BITS   = 16,
    parameter int ROW_BITS   = 10,
    parameter int COL_BITS   = 10,
    parameter int MAX_SCALES = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_start,
    input  logic [ROW_BITS-1:0]   cfg_base_w,
    input  logic [COL_BITS-1:0]   cfg_base_h,
    input  logic [FIXED_BITS-1:0] cfg_scale_step,
    input  logic [WIN_BITS-1:0]   cfg_win_size,
    input  logic [WIN_BITS-1:0]   cfg_min_win_size,
    input  logic [FIXED_BITS-1:0] cfg_win_inv,
    input  logic [7:0]            cfg_stages,
    output logic                  spg_rst_n,
    output logic                  spg_start,
    output logic                  spg_taken,
    output logic [ROW_BITS-1:0]   spg_base_w,
    output logic [COL_BITS-1:0]   spg_base_h,
    output logic [FIXED_BITS-1:0] spg_base_scale_step,
    output logic [WIN_BITS-1:0]   spg_base_win_size,
    output logic [WIN_BITS-1:0]   spg_base_min_win_size,
    output logic [FIXED_BITS-1:0] spg_base_win_inv,
    output logic [7:0]            spg_base_stages,
    input  logic                  spg_ready,
    input  logic                  spg_done,
    input  logic [ROW_BITS-1:0]   spg_scale_w,
    input  logic [COL_BITS-1:0]   spg_scale_h,
    input  logic [FIXED_BITS-1:0] spg_sfx,
    input  logic [FIXED_BITS-1:0] spg_sfy,
    input  logic [WIN_BITS-1:0]   spg_true_win,
    scale_param_sequencer_if.master sif,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            num_scales
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_READY,
        S_START,
        S_WAIT_DONE,
        S_CHECK,
        S_PRESENT,
        S_FRAME_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ROW_BITS-1:0]   rec_w;
    logic [COL_BITS-1:0]   rec_h;
    logic [FIXED_BITS-1:0] rec_sfx;
    logic [FIXED_BITS-1:0] rec_sfy;
    logic [WIN_BITS-1:0]   rec_win;
    logic [7:0]            rec_idx;
    logic [8:0]            idx_inc;
    logic                  too_small;
    logic                  last_scale;
    logic                  valid_c;

    // The window threshold is the latched copy, so cfg edits mid-frame
    // cannot change which scales pass.
    assign too_small  = (WIN_BITS'(rec_w) < spg_base_win_size) ||
                        (WIN_BITS'(rec_h) < spg_base_win_size);
    assign idx_inc    = {1'b0, rec_idx} + 9'd1;
    assign last_scale = (idx_inc == 9'(MAX_SCALES));
    assign spg_rst_n  = resetn & (state != S_CLEAR);
    assign busy       = (state != S_IDLE);

    assign sif.scale_valid    = valid_c;
    assign sif.scale_w        = rec_w;
    assign sif.scale_h        = rec_h;
    assign sif.scale_sfx      = rec_sfx;
    assign sif.scale_sfy      = rec_sfy;
    assign sif.scale_true_win = rec_win;
    assign sif.scale_idx      = rec_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and one-cycle strobes.
    always_comb begin
        state_nxt  = state;
        spg_start  = 1'b0;
        spg_taken  = 1'b0;
        valid_c    = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                state_nxt = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (spg_ready) state_nxt = S_START;
            end
            S_START: begin
                spg_start = 1'b1;
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (spg_done) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                spg_taken = 1'b1;
                state_nxt = too_small ? S_FRAME_DONE : S_PRESENT;
            end
            S_PRESENT: begin
                valid_c = 1'b1;
                if (sif.scale_accept)
                    state_nxt = last_scale ? S_FRAME_DONE : S_WAIT_READY;
            end
            S_FRAME_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Config latch, result capture, scale index and per-frame count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            spg_base_w            <= '0;
            spg_base_h            <= '0;
            spg_base_scale_step   <= '0;
            spg_base_win_size     <= '0;
            spg_base_min_win_size <= '0;
            spg_base_win_inv      <= '0;
            spg_base_stages       <= '0;
            rec_w                 <= '0;
            rec_h                 <= '0;
            rec_sfx               <= '0;
            rec_sfy               <= '0;
            rec_win               <= '0;
            rec_idx               <= '0;
            num_scales            <= '0;
        end else begin
            if (state == S_IDLE && frame_start) begin
                spg_base_w            <= cfg_base_w;
                spg_base_h            <= cfg_base_h;
                spg_base_scale_step   <= cfg_scale_step;
                spg_base_win_size     <= cfg_win_size;
                spg_base_min_win_size <= cfg_min_win_size;
                spg_base_win_inv      <= cfg_win_inv;
                spg_base_stages       <= cfg_stages;
                rec_idx               <= '0;
            end
            if (state == S_WAIT_DONE && spg_done) begin
                rec_w   <= spg_scale_w;
                rec_h   <= spg_scale_h;
                rec_sfx <= spg_sfx;
                rec_sfy <= spg_sfy;
                rec_win <= spg_true_win;
            end
            if (state == S_PRESENT && sif.scale_accept)
                rec_idx <= idx_inc[7:0];
            if (state == S_FRAME_DONE)
                num_scales <= rec_idx;
        end
    end

endmodule

// File: tb/tb_scale_param_sequencer.sv
// Randomized bench for scale_param_sequencer: a behavioural generator
// model, a random downstream consumer and table-derived expectations.
module tb_scale_param_sequencer;

    localparam int FB = 32;
    localparam int WB = 16;
    localparam int RB = 10;
    localparam int CB = 10;
    localparam int MS = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic          frame_start;
    logic [RB-1:0] cfg_base_w;
    logic [CB-1:0] cfg_base_h;
    logic [FB-1:0] cfg_scale_step;
    logic [WB-1:0] cfg_win_size;
    logic [WB-1:0] cfg_min_win_size;
    logic [FB-1:0] cfg_win_inv;
    logic [7:0]    cfg_stages;
    logic          spg_rst_n;
    logic          spg_start;
    logic          spg_taken;
    logic [RB-1:0] spg_base_w;
    logic [CB-1:0] spg_base_h;
    logic [FB-1:0] spg_base_scale_step;
    logic [WB-1:0] spg_base_win_size;
    logic [WB-1:0] spg_base_min_win_size;
    logic [FB-1:0] spg_base_win_inv;
    logic [7:0]    spg_base_stages;
    logic          spg_ready;
    logic          spg_done;
    logic [RB-1:0] spg_scale_w;
    logic [CB-1:0] spg_scale_h;
    logic [FB-1:0] spg_sfx;
    logic [FB-1:0] spg_sfy;
    logic [WB-1:0] spg_true_win;
    logic          busy;
    logic          frame_done;
    logic [7:0]    num_scales;

    scale_param_sequencer_if #(
        .FIXED_BITS(FB), .WIN_BITS(WB), .ROW_BITS(RB), .COL_BITS(CB)
    ) sif ();

    scale_param_sequencer #(
        .FIXED_BITS(FB), .WIN_BITS(WB), .ROW_BITS(RB), .COL_BITS(CB),
        .MAX_SCALES(MS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .frame_start(frame_start),
        .cfg_base_w(cfg_base_w),
        .cfg_base_h(cfg_base_h),
        .cfg_scale_step(cfg_scale_step),
        .cfg_win_size(cfg_win_size),
        .cfg_min_win_size(cfg_min_win_size),
        .cfg_win_inv(cfg_win_inv),
        .cfg_stages(cfg_stages),
        .spg_rst_n(spg_rst_n),
        .spg_start(spg_start),
        .spg_taken(spg_taken),
        .spg_base_w(spg_base_w),
        .spg_base_h(spg_base_h),
        .spg_base_scale_step(spg_base_scale_step),
        .spg_base_win_size(spg_base_win_size),
        .spg_base_min_win_size(spg_base_min_win_size),
        .spg_base_win_inv(spg_base_win_inv),
        .spg_base_stages(spg_base_stages),
        .spg_ready(spg_ready),
        .spg_done(spg_done),
        .spg_scale_w(spg_scale_w),
        .spg_scale_h(spg_scale_h),
        .spg_sfx(spg_sfx),
        .spg_sfy(spg_sfy),
        .spg_true_win(spg_true_win),
        .sif(sif),
        .busy(busy),
        .frame_done(frame_done),
        .num_scales(num_scales)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Generator result table for the current frame, plus model state.
    int tab_w[$];
    int tab_h[$];
    int gptr      = 0;
    int gdly      = 0;
    int rcnt      = 0;
    bit gbusy     = 1'b0;
    bit gstall    = 1'b0;
    int taken_cnt = 0;

    // Downstream / scoreboard state.
    int n_exp    = 0;
    int xfer_cnt = 0;
    int hold_req = 0;
    int fd_cnt   = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FB-1:0] f_sfx(input int k);
        return 32'h0001_0000 + 32'(k) * 32'h0000_3333;
    endfunction

    function automatic logic [FB-1:0] f_sfy(input int k);
        return f_sfx(k) + 32'h0000_0011;
    endfunction

    function automatic logic [WB-1:0] f_tw(input int k);
        return 16'(24 + 2 * k);
    endfunction

    // Behavioural scale-parameter generator with random latencies.
    always @(negedge clk) begin
        if (!spg_rst_n) begin
            spg_ready = 1'b0;
            spg_done  = 1'b0;
            gbusy     = 1'b0;
            gptr      = 0;
            rcnt      = $urandom_range(0, 2);
        end else if (spg_start) begin
            chk("start_while_ready", spg_ready, 1'b1);
            spg_ready = 1'b0;
            gbusy     = 1'b1;
            gdly      = $urandom_range(0, 3);
        end else if (gbusy) begin
            if (!gstall) begin
                if (gdly == 0) begin
                    gbusy        = 1'b0;
                    spg_done     = 1'b1;
                    spg_scale_w  = RB'(tab_w[gptr]);
                    spg_scale_h  = CB'(tab_h[gptr]);
                    spg_sfx      = f_sfx(gptr);
                    spg_sfy      = f_sfy(gptr);
                    spg_true_win = f_tw(gptr);
                end else begin
                    gdly--;
                end
            end
        end else if (spg_taken) begin
            chk("taken_with_done", spg_done, 1'b1);
            spg_done = 1'b0;
            gptr++;
            taken_cnt++;
            rcnt = $urandom_range(0, 2);
        end else if (!spg_done && !spg_ready) begin
            if (rcnt == 0) spg_ready = 1'b1;
            else           rcnt--;
        end
    end

    // Random consumer; every presented record is checked against the table.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (sif.scale_valid) begin
            chk("valid_in_range", xfer_cnt < n_exp, 1'b1);
            if (xfer_cnt < n_exp) begin
                chk("rec_geom",
                    {sif.scale_w, sif.scale_h, sif.scale_true_win,
                     sif.scale_idx},
                    {RB'(tab_w[xfer_cnt]), CB'(tab_h[xfer_cnt]),
                     f_tw(xfer_cnt), 8'(xfer_cnt)});
                chk("rec_factors", {sif.scale_sfx, sif.scale_sfy},
                    {f_sfx(xfer_cnt), f_sfy(xfer_cnt)});
            end
            chk("no_start_while_valid", spg_start, 1'b0);
            if (hold_req > 0) begin
                hold_req--;
                sif.scale_accept = 1'b0;
            end else begin
                sif.scale_accept = ($urandom_range(0, 2) != 0);
            end
            if (sif.scale_accept) xfer_cnt++;
        end else begin
            sif.scale_accept = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic run_frame(input string tag, input int win, input bit poke);
        int fd0;
        int exp_taken;
        bit seen;
        n_exp = 0;
        while (n_exp < tab_w.size() && n_exp < MS &&
               tab_w[n_exp] >= win && tab_h[n_exp] >= win)
            n_exp++;
        exp_taken = (n_exp < MS) ? n_exp + 1 : n_exp;
        xfer_cnt  = 0;
        taken_cnt = 0;
        fd0       = fd_cnt;
        @(negedge clk);
        cfg_base_w     = 10'd320;
        cfg_base_h     = 10'd240;
        cfg_scale_step = 32'h0001_4000;
        cfg_win_size   = WB'(win);
        cfg_win_inv    = 32'h0000_0AAB;
        cfg_stages     = 8'd25;
        frame_start    = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        if (poke) begin
            repeat (3) @(negedge clk);
            cfg_win_size = 16'd200;
            cfg_base_w   = 10'd5;
            frame_start  = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) seen = 1'b1;
        end
        chk({tag, "_frame_done"}, seen, 1'b1);
        @(posedge clk);
        #1;
        chk({tag, "_num_scales"}, num_scales, 8'(n_exp));
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_transfers"}, 32'(xfer_cnt), 32'(n_exp));
        chk({tag, "_taken"}, 32'(taken_cnt), 32'(exp_taken));
        chk({tag, "_base"}, {spg_base_w, spg_base_h, spg_base_win_size,
                             spg_base_stages},
            {10'd320, 10'd240, WB'(win), 8'd25});
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_one_done"}, 32'(fd_cnt - fd0), 32'd1);
        chk({tag, "_stays_idle"}, busy, 1'b0);
    endtask

    initial begin
        int win;
        resetn           = 1'b0;
        frame_start      = 1'b0;
        cfg_base_w       = '0;
        cfg_base_h       = '0;
        cfg_scale_step   = '0;
        cfg_win_size     = '0;
        cfg_min_win_size = 16'd24;
        cfg_win_inv      = '0;
        cfg_stages       = '0;
        spg_ready        = 1'b0;
        spg_done         = 1'b0;
        spg_scale_w      = '0;
        spg_scale_h      = '0;
        spg_sfx          = '0;
        spg_sfy          = '0;
        spg_true_win     = '0;
        sif.scale_accept = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs",
            {spg_rst_n, spg_start, spg_taken, busy, frame_done,
             sif.scale_valid, num_scales, sif.scale_idx},
            '0);
        chk("rst_base", {spg_base_w, spg_base_win_size}, '0);
        @(negedge clk);
        resetn = 1'b1;

        // Nominal 320x240 pyramid, window 24.
        tab_h = '{240, 192, 154, 123, 98, 79, 63, 50, 40, 32, 26, 20};
        tab_w = '{320, 256, 205, 164, 131, 105, 84, 67, 53, 43, 35, 27};
        run_frame("pyramid", 24, 1'b0);

        // First scale held off by the consumer for 7 cycles.
        hold_req = 7;
        run_frame("hold", 24, 1'b0);

        // Generator never shrinks: frame ends on the scale cap.
        tab_w = {};
        tab_h = {};
        for (int i = 0; i < MS + 2; i++) begin
            tab_w.push_back(100);
            tab_h.push_back(100);
        end
        run_frame("cap", 24, 1'b0);

        // First result already below the window.
        tab_w = '{20};
        tab_h = '{20};
        run_frame("immediate", 24, 1'b0);

        // Reset while waiting on a stalled generator.
        gstall = 1'b1;
        tab_w  = '{100, 100};
        tab_h  = '{100, 100};
        n_exp  = 0;
        @(negedge clk);
        cfg_win_size = 16'd24;
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (12) @(negedge clk);
        chk("stall_busy", {busy, spg_done, sif.scale_valid}, 3'b100);
        begin
            int fd0;
            fd0 = fd_cnt;
            resetn = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst_state",
                {busy, spg_rst_n, frame_done, sif.scale_valid},
                4'b0000);
            @(negedge clk);
            resetn = 1'b1;
            gstall = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("midrst_no_done", 32'(fd_cnt - fd0), 32'd0);
            chk("midrst_idle", busy, 1'b0);
        end
        tab_h = '{240, 192, 154, 123, 98, 79, 63, 50, 40, 32, 26, 20};
        tab_w = '{320, 256, 205, 164, 131, 105, 84, 67, 53, 43, 35, 27};
        run_frame("after_rst", 24, 1'b0);

        // Width exactly at the window passes; late start and cfg edits ignored.
        tab_w = '{24, 24, 23};
        tab_h = '{30, 24, 40};
        run_frame("boundary", 24, 1'b1);

        // Random scale tables and window sizes.
        for (int f = 0; f < 5; f++) begin
            win   = $urandom_range(8, 40);
            tab_w = {};
            tab_h = {};
            for (int i = 0; i < MS + 2; i++) begin
                tab_w.push_back($urandom_range(win - 3, win + 80));
                tab_h.push_back($urandom_range(win - 3, win + 80));
            end
            run_frame("random", win, 1'(f % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
